// File: rtl/cpu_rf_pkg.sv
// Shared register-file constants and types for the CPU write-back path.
package cpu_rf_pkg;

    localparam int RF_ADDR_W   = 2;
    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 4;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : cpu_rf_pkg

// File: rtl/rr_arbiter.sv
// Generic NUM_REQ-wide arbiter producing a one-hot grant.
// Default build: round-robin starting from a pointer that moves past each winner.
// With REGFILE_WB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, no pointer.
// Grants are only ever given to asserted requests, so a grant is a transfer.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

`ifdef REGFILE_WB_FIXED_PRIO_EN

    // Fixed priority needs no state; the clock is intentionally unused.
    logic unused_clk;
    assign unused_clk = clk;

    // Lowest asserted index wins; nothing is granted while in reset.
    always_comb begin
        logic found;
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (rst) begin
            gnt_o = '0;
        end
    end

`else

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Search upward from the pointer with wrap; the winner's successor becomes the next pointer.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer a latch.
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_d      = PTR_W'((int'(idx) + 1) % NUM_REQ);
                found      = 1'b1;
            end
        end
        if (rst) begin
            gnt_o = '0;
        end
    end

    // Pointer register: returns to 0 on reset, otherwise follows the last winner.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and scoreboard for the 4x16 register file.
// Shares the single write port among NUM_REQ producers, registers the write
// one cycle after the handshake, and tracks pending destinations to stall issue.
// Build option: REGFILE_WB_FIXED_PRIO_EN selects fixed-priority arbitration.
module regfile_wb_arbiter
    import cpu_rf_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_w_addr,
    output logic [DATA_W-1:0]         rf_w_data,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic                      rd_use1,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic                      rd_use2,
    input  logic [ADDR_W-1:0]         rd_addr2,
    output logic                      rd_stall,
    output logic [NUM_REGS-1:0]       pending,
    output logic                      err_double_rsv
);

    logic                rf_we_q,     rf_we_d;
    logic [ADDR_W-1:0]   rf_w_addr_q, rf_w_addr_d;
    logic [DATA_W-1:0]   rf_w_data_q, rf_w_data_d;
    logic [NUM_REGS-1:0] pending_q,   pending_d;
    logic                err_q,       err_d;

    logic                xfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                clr_hits_rsv;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_valid),
        .gnt_o (req_ready)
    );

    // Route the granted requester's address/data to the write-out register.
    always_comb begin
        xfer     = |(req_valid & req_ready);
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
        rf_we_d     = xfer;
        rf_w_addr_d = xfer ? sel_addr : rf_w_addr_q;
        rf_w_data_d = xfer ? sel_data : rf_w_data_q;
    end

    // Scoreboard update: commit clears first, reservation sets after, so set wins on a collision.
    always_comb begin
        clr_hits_rsv = rf_we_q && (rf_w_addr_q == rsv_addr);
        pending_d    = pending_q;
        if (rf_we_q) begin
            pending_d[rf_w_addr_q] = 1'b0;
        end
        if (rsv_valid) begin
            pending_d[rsv_addr] = 1'b1;
        end
        err_d = err_q | (rsv_valid & pending_q[rsv_addr] & ~clr_hits_rsv);
    end

    // Write-out and scoreboard registers; reset drops any accepted-but-unwritten transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q     <= 1'b0;
            rf_w_addr_q <= '0;
            rf_w_data_q <= '0;
            pending_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_w_addr_q <= rf_w_addr_d;
            rf_w_data_q <= rf_w_data_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_w_addr      = rf_w_addr_q;
    assign rf_w_data      = rf_w_data_q;
    assign pending        = pending_q;
    assign err_double_rsv = err_q;
    assign rd_stall       = (rd_use1 & pending_q[rd_addr1]) | (rd_use2 & pending_q[rd_addr2]);

endmodule : regfile_wb_arbiter
